// File: rtl/iobus_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : Bus_if
// Brief    : OCP-style command/response bus shared between the arbiter and
//            the iobus slave.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface Bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [2:0]              MCmd;
    logic [ADDR_WIDTH-1:0]   MAddr;
    logic [DATA_WIDTH-1:0]   MData;
    logic [DATA_WIDTH/8-1:0] MByteEn;
    logic                    SCmdAccept;
    logic [1:0]              SResp;
    logic [DATA_WIDTH-1:0]   SData;

    modport master (
        output MCmd, MAddr, MData, MByteEn,
        input  SCmdAccept, SResp, SData
    );

    modport slave (
        input  MCmd, MAddr, MData, MByteEn,
        output SCmdAccept, SResp, SData
    );
endinterface

`default_nettype wire

// File: rtl/iobus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : iobus_arbiter
// Brief    : Round-robin arbiter sharing one iobus slave between NUM_MASTERS
//            requesters, with in-order response routing via an ID FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iobus_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WRITE_RESP      = 1,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS*3-1:0]          m_mcmd,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_maddr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_mdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_mbyteen,
    output logic [NUM_MASTERS-1:0]            m_scmdaccept,
    output logic [NUM_MASTERS*2-1:0]          m_sresp,
    output logic [DATA_WIDTH-1:0]             m_sdata,
    Bus_if.master                             iobus,
    output logic                              err_orphan_resp
);

    localparam int c_ID_W  = $clog2(NUM_MASTERS);
    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_BE_W  = DATA_WIDTH / 8;

    localparam logic [2:0]         c_CMD_IDLE  = 3'd0;
    localparam logic [2:0]         c_CMD_WR    = 3'd1;
    localparam logic [1:0]         c_RESP_NULL = 2'd0;
    localparam logic [c_CNT_W-1:0] c_MAX_OUT   = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [c_ID_W-1:0]  c_RR_INIT   = c_ID_W'(NUM_MASTERS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_ID_W-1:0]   r_gnt_id;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_ID_W-1:0]   r_fifo [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_err;

    logic                w_any_req;
    logic [c_ID_W-1:0]   w_pick;
    logic [2:0]          w_gnt_cmd;
    logic                w_accept;
    logic                w_drop;
    logic                w_push;
    logic                w_rsp_valid;
    logic                w_pop;
    logic                w_orphan;
    int                  w_idx;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Scan downward so the requester closest after rr_ptr overwrites the others.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        w_idx     = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_MASTERS;
            if (m_mcmd[w_idx*3 +: 3] != c_CMD_IDLE) begin
                w_any_req = 1'b1;
                w_pick    = c_ID_W'(w_idx);
            end
        end
    end

    assign w_gnt_cmd = m_mcmd[r_gnt_id*3 +: 3];

    always_comb begin
        iobus.MCmd    = c_CMD_IDLE;
        iobus.MAddr   = '0;
        iobus.MData   = '0;
        iobus.MByteEn = '0;
        m_scmdaccept  = '0;
        w_accept      = 1'b0;
        w_drop        = 1'b0;
        w_push        = 1'b0;
        if (r_state == S_GRANT) begin
            iobus.MCmd    = w_gnt_cmd;
            iobus.MAddr   = m_maddr[r_gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
            iobus.MData   = m_mdata[r_gnt_id*DATA_WIDTH +: DATA_WIDTH];
            iobus.MByteEn = m_mbyteen[r_gnt_id*c_BE_W +: c_BE_W];
            if (w_gnt_cmd == c_CMD_IDLE) begin
                w_drop = 1'b1;
            end else if (iobus.SCmdAccept) begin
                m_scmdaccept[r_gnt_id] = 1'b1;
                w_accept = 1'b1;
                w_push   = !((w_gnt_cmd == c_CMD_WR) && (WRITE_RESP == 0));
            end
        end
    end

    assign w_rsp_valid = (iobus.SResp != c_RESP_NULL);
    assign w_pop       = w_rsp_valid && (r_count != '0);
    assign w_orphan    = w_rsp_valid && (r_count == '0);

    always_comb begin
        m_sresp = '0;
        if (w_pop) begin
            m_sresp[r_fifo[r_rd_ptr]*2 +: 2] = iobus.SResp;
        end
    end

    // Data is broadcast, but forced quiet while reset is held.
    assign m_sdata         = reset ? iobus.SData : '0;
    assign err_orphan_resp = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_gnt_id <= '0;
            r_rr_ptr <= c_RR_INIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req && (r_count < c_MAX_OUT)) begin
                        r_gnt_id <= w_pick;
                        r_state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_drop) begin
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        r_rr_ptr <= r_gnt_id;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_orphan) begin
                r_err <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_gnt_id;
        end
    end

endmodule

`default_nettype wire
